// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Function : One-shot PWM brightness fade (ramp up, hold, ramp down) driving
//            its own PWM counter and compare; duty moves only at period ends.
// Revision : 1.0
// ============================================================================
module pwm_fade_ctrl #(
    parameter int CBITS        = 12,
    parameter int STEP         = 128,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sw,
    input  logic             start,
    input  logic             abort,
    output logic [CBITS-1:0] duty,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RAMP_UP   = 2'd1;
    localparam logic [1:0] c_HOLD      = 2'd2;
    localparam logic [1:0] c_RAMP_DOWN = 2'd3;

    localparam int c_SPW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int c_HPW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [c_SPW-1:0] c_STEP_LAST = c_SPW'(STEP_PERIODS - 1);
    localparam logic [c_HPW-1:0] c_HOLD_LAST = c_HPW'(HOLD_PERIODS - 1);
    localparam logic [c_SPW-1:0] c_SP_ONE    = c_SPW'(1);
    localparam logic [c_HPW-1:0] c_HP_ONE    = c_HPW'(1);
    localparam logic [CBITS-1:0] c_STEP      = CBITS'(STEP);
    localparam logic [CBITS-1:0] c_CNT_ONE   = CBITS'(1);

    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] r_duty;
    logic             r_pulse;
    logic [CBITS-1:0] r_target;
    logic [c_SPW-1:0] r_step_cnt;
    logic [c_HPW-1:0] r_hold_cnt;
    logic [1:0]       r_state;
    logic             r_done;

    logic             w_period_end;
    logic [CBITS:0]   w_sum;
    logic [CBITS-1:0] w_duty_up;
    logic [CBITS-1:0] w_duty_dn;
    logic [CBITS-1:0] w_target_new;
    logic             w_unused_sw;

    assign w_period_end = (r_cnt == '1);
    // Sum is one bit wider so a ramp near full scale saturates instead of wrapping.
    assign w_sum        = {1'b0, r_duty} + {1'b0, c_STEP};
    assign w_duty_up    = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[CBITS-1:0];
    assign w_duty_dn    = (r_duty > c_STEP) ? (r_duty - c_STEP) : '0;
    assign w_target_new = {1'b0, sw[3:1], 1'b1, {(CBITS-5){1'b0}}};
    assign w_unused_sw  = sw[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
            r_pulse <= (r_cnt < r_duty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_duty     <= '0;
            r_target   <= '0;
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_RAMP_UP;
                        r_target   <= w_target_new;
                        r_step_cnt <= '0;
                    end
                end
                c_RAMP_UP: begin
                    if (abort) begin
                        r_state    <= c_RAMP_DOWN;
                        r_step_cnt <= '0;
                    end else if (w_period_end) begin
                        if (r_step_cnt == c_STEP_LAST) begin
                            r_step_cnt <= '0;
                            r_duty     <= w_duty_up;
                            if (w_duty_up == r_target) begin
                                r_state    <= c_HOLD;
                                r_hold_cnt <= '0;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + c_SP_ONE;
                        end
                    end
                end
                c_HOLD: begin
                    if (abort) begin
                        r_state    <= c_RAMP_DOWN;
                        r_step_cnt <= '0;
                    end else if (w_period_end) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state    <= c_RAMP_DOWN;
                            r_step_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HP_ONE;
                        end
                    end
                end
                c_RAMP_DOWN: begin
                    if (w_period_end) begin
                        if (r_step_cnt == c_STEP_LAST) begin
                            r_step_cnt <= '0;
                            r_duty     <= w_duty_dn;
                            if (w_duty_dn == '0) begin
                                r_state <= c_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + c_SP_ONE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign duty  = r_duty;
    assign pulse = r_pulse;
    assign busy  = (r_state != c_IDLE);
    assign done  = r_done;
    assign state = r_state;

endmodule
`default_nettype wire

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Sequencer for a free-running PWM duty datapath. It runs one brightness "fade" per start request: it ramps the duty word from 0 up to a switch-selected target, holds it, then ramps back to 0. Duty changes only at PWM period boundaries, so the generated pulse never glitches mid-period. It sits between the board switches/start logic and the LED pulse output, and owns both the PWM counter and the compare.

Parameters:
CBITS, 12, width of PWM counter and duty word; period = 2^CBITS clk cycles
STEP, 128, duty increment/decrement per ramp step; default 2^(CBITS-5)
STEP_PERIODS, 4, PWM periods between ramp steps (>=1)
HOLD_PERIODS, 8, PWM periods spent at target before ramping down (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sw  input  4  target level select, sampled only when a start is accepted
start  input  1  single-cycle request to begin a fade; ignored while busy
abort  input  1  force early ramp-down; honoured in RAMP_UP/HOLD only
duty  output  CBITS  current duty word (registered)
pulse  output  1  PWM output, registered
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the ramp-down reaches 0
state  output  2  IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3

Behaviour:
- Reset (sync, rst=1 at a clk edge): cnt=0, duty=0, pulse=0, state=IDLE, period/step counters=0, done=0, busy=0, target=0. rst takes precedence over all other inputs, including mid-fade.
- cnt: CBITS-bit free-running counter, +1 every cycle, wraps at all-ones. It is never cleared by start or abort. period_end = (cnt == all-ones).
- pulse <= (cnt < duty), registered. This gives 1-cycle latency from cnt. duty=0 gives a constant 0.
- Target latched on accepted start: {1'b0, sw[3:1], 1'b1, (CBITS-5) zero bits}. For CBITS=12 the range is 128..1920. STEP must divide the target; otherwise the saturation rules below still apply.
- Accepted start: start=1 while state=IDLE. The next cycle has state=RAMP_UP and busy=1. The step counter is cleared.
- Step counter increments only on period_end. When it equals STEP_PERIODS-1 on a period_end, the counter clears and a step is applied on that same edge:
  - RAMP_UP: duty <= min(duty+STEP, target). Sum computed CBITS+1 wide; no wrap. If the new duty == target, go to HOLD with the hold counter cleared.
  - RAMP_DOWN: duty <= max(duty-STEP, 0), saturating. If the new duty == 0, go to IDLE and pulse done for 1 cycle.
- HOLD: the hold counter increments on period_end. On the period_end where it equals HOLD_PERIODS-1, go to RAMP_DOWN with the step counter cleared. Duty is unchanged.
- abort=1 in RAMP_UP or HOLD: next cycle state=RAMP_DOWN, step counter cleared, duty kept. abort is ignored in IDLE and RAMP_DOWN.
- start and abort in the same cycle in IDLE: start wins; abort is ignored.
- start while busy: ignored; target is not re-sampled.
- Because duty only changes on a period_end edge, a PWM period always uses a single duty value.
- done and start in the same cycle: done is asserted in IDLE, so a start in that cycle is accepted.

Test Plan:
1. Bench params CBITS=8, STEP=8, STEP_PERIODS=2, HOLD_PERIODS=3; rst for 2 cycles -> duty=0, pulse=0, state=0, busy=0, done=0; pulse stays 0 for 512 cycles.
2. sw=4'b1111, start pulse -> target=120. duty steps 8,16,...,120, once per 2 periods (15 steps). State goes to 2 on the step reaching 120. After 3 periods state=3. duty falls 112..0 in 15 steps, then done=1 for exactly 1 cycle and state=0.
3. sw=4'b0000 -> target=8. A single step reaches 8 and goes to HOLD. After 3 periods one down step gives 0 and done fires. Total duration 2+3+2 = 7 periods after the first aligned period_end.
4. Duty/pulse check at duty=40: pulse high for exactly 40 consecutive cycles per 256-cycle period. It changes only after a cnt=255 edge.
5. abort during RAMP_UP at duty=48 -> next cycle state=3, duty holds 48, then ramps 40..0 and done fires. A second start during RAMP_DOWN is ignored (target unchanged).
6. rst asserted mid-HOLD at duty=120 -> next cycle duty=0, state=0, pulse=0, busy=0, no done. A new start is accepted the following cycle.
